// File: rtl/matrix_result_uart_tx_if.sv
// matrix_result_uart_tx_if
//   Bundles the result-store read port, the frame request/status handshake
//   and the UART line of matrix_result_uart_tx.
//   send      : frame request (host/controller -> transmitter)
//   rd_index  : element index presented to the result store
//   rd_data   : element value, valid 2 cycles after rd_index changes
//   tx        : UART 8N1 serial output, idle high
//   busy      : high while a frame is in progress
//   done      : one-cycle pulse at frame end
//   last_byte : byte currently or most recently on tx
//   master = transmitter side, slave = store/controller side.
interface matrix_result_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      send;
    logic [3:0]                rd_index;
    logic [2*DATA_WIDTH-1:0]   rd_data;
    logic                      tx;
    logic                      busy;
    logic                      done;
    logic [7:0]                last_byte;

    modport master (
        input  send, rd_data,
        output rd_index, tx, busy, done, last_byte
    );

    modport slave (
        output send, rd_data,
        input  rd_index, tx, busy, done, last_byte
    );
endinterface

// File: rtl/matrix_result_uart_tx.sv
// matrix_result_uart_tx
//   Streams the 3x3 result matrix over UART 8N1 as one frame:
//   HEADER, {MSB byte, LSB byte} per element, then an 8-bit checksum
//   (sum mod 256 of all element bytes, header excluded).
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-high reset
//     bus : matrix_result_uart_tx_if.master (send, rd_index, rd_data,
//           tx, busy, done, last_byte)
module matrix_result_uart_tx #(
    parameter int         DATA_WIDTH   = 8,
    parameter int         NUM_ELEMS    = 9,
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    matrix_result_uart_tx_if.master bus
);

    // Counter is at least one bit wide so CLKS_PER_BIT=1 still works.
    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LAST_ELEM = 4'(NUM_ELEMS - 1);

    typedef enum logic [2:0] {IDLE, HDR, HI, LO, CSUM} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;    // 0 = start, 1..8 = data, 9 = stop
    logic [3:0]    elem_idx;
    logic [7:0]    shreg;
    logic [7:0]    elem_lo;
    logic [7:0]    csum;
    logic [7:0]    next_byte;
    logic          bit_end;
    logic          byte_end;

    logic          tx_r;
    logic          busy_r;
    logic          done_r;
    logic [3:0]    rd_index_r;
    logic [7:0]    last_byte_r;

    assign bus.tx        = tx_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.rd_index  = rd_index_r;
    assign bus.last_byte = last_byte_r;

    // Byte to load when the current byte's stop bit ends. The MSB byte
    // comes straight from rd_data, captured on that same cycle.
    always_comb begin
        bit_end    = (clk_cnt == CNT_MAX);
        byte_end   = bit_end && (bit_idx == 4'd9);
        next_byte  = HEADER;
        next_state = IDLE;
        case (state)
            HDR: begin
                next_byte  = bus.rd_data[2*DATA_WIDTH-1 -: 8];
                next_state = HI;
            end
            HI: begin
                next_byte  = elem_lo;
                next_state = LO;
            end
            LO: begin
                if (elem_idx == LAST_ELEM) begin
                    next_byte  = csum;
                    next_state = CSUM;
                end else begin
                    next_byte  = bus.rd_data[2*DATA_WIDTH-1 -: 8];
                    next_state = HI;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            elem_idx    <= '0;
            shreg       <= '0;
            elem_lo     <= '0;
            csum        <= '0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_index_r  <= '0;
            last_byte_r <= '0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                tx_r       <= 1'b1;
                busy_r     <= 1'b0;
                rd_index_r <= '0;
                clk_cnt    <= '0;
                bit_idx    <= '0;
                if (bus.send) begin
                    state       <= HDR;
                    busy_r      <= 1'b1;
                    tx_r        <= 1'b0;
                    shreg       <= HEADER;
                    last_byte_r <= HEADER;
                    csum        <= '0;
                    elem_idx    <= '0;
                end
            end else if (!bit_end) begin
                clk_cnt <= clk_cnt + 1'b1;
            end else begin
                clk_cnt <= '0;
                if (!byte_end) begin
                    bit_idx <= bit_idx + 1'b1;
                    tx_r    <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
                end else begin
                    bit_idx <= '0;
                    if (state == CSUM) begin
                        state      <= IDLE;
                        tx_r       <= 1'b1;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        rd_index_r <= '0;
                    end else begin
                        // Next start bit begins immediately: no idle gap.
                        state       <= next_state;
                        tx_r        <= 1'b0;
                        shreg       <= next_byte;
                        last_byte_r <= next_byte;
                        csum        <= csum + next_byte;
                        if (state == HDR) begin
                            elem_lo <= bus.rd_data[7:0];
                        end
                        if (state == LO && elem_idx != LAST_ELEM) begin
                            elem_idx <= elem_idx + 4'd1;
                            elem_lo  <= bus.rd_data[7:0];
                        end
                        // Fetch the next element as its preceding LO byte starts.
                        if (state == HI && elem_idx != LAST_ELEM) begin
                            rd_index_r <= elem_idx + 4'd1;
                        end
                    end
                end
            end
        end
    end

endmodule
